// File: rtl/con_acc_pipe.sv
// Pipelined convolution MAC: signed-weight x unsigned-pixel products, registered adder tree,
// per-group channel accumulation with bias, round/shift requantisation, optional ReLU, saturation.
module con_acc_pipe #(
    parameter int DATA  = 16,
    parameter int IMA   = 8,
    parameter int NUM   = 49,
    parameter int CH    = 4,
    parameter int OUT   = 16,
    parameter int SHIFT = 8,
    parameter int RELU  = 1,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    input  logic [DATA*NUM-1:0]   wei_i,
    input  logic [IMA*NUM-1:0]    ima_i,
    input  logic [DATA-1:0]       bias_i,
    input  logic                  clear_i,
    output logic                  out_valid_o,
    output logic [OUT-1:0]        out_data_o,
    output logic [CW-1:0]         ch_idx_o
);

    localparam int P = DATA + IMA + 1;
    localparam int T = $clog2(NUM);
    localparam int S = P + T;
    localparam int A = S + ((CH > 1) ? $clog2(CH) : 0) + 1;
    localparam int R = A + 1;
    localparam logic signed [R-1:0] RND  = (SHIFT > 0) ? (R'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [R-1:0] MAXV = {{(R-OUT+1){1'b0}}, {(OUT-1){1'b1}}};
    localparam logic signed [R-1:0] MINV = {{(R-OUT+1){1'b1}}, {(OUT-1){1'b0}}};

    logic signed [P-1:0] prod_w [NUM];
    logic signed [S-1:0] tree_q [T+1][NUM];
    logic [T:0]          v_q;

    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            prod_w[k] = $signed(P'($signed(wei_i[DATA*k +: DATA])))
                      * $signed(P'({1'b0, ima_i[IMA*k +: IMA]}));
        end
    end

    // Slots past each level's live element count hold zero, so pairwise sums stay exact
    // and an odd trailing element effectively passes through.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            v_q <= '0;
            for (int l = 0; l <= T; l++) begin
                for (int i = 0; i < NUM; i++) tree_q[l][i] <= '0;
            end
        end else begin
            v_q <= clear_i ? '0 : {v_q[T-1:0], in_valid_i};
            for (int k = 0; k < NUM; k++) begin
                tree_q[0][k] <= {{T{prod_w[k][P-1]}}, prod_w[k]};
            end
            for (int l = 1; l <= T; l++) begin
                for (int i = 0; i < NUM / 2; i++) begin
                    tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
                end
                if (NUM % 2 == 1) tree_q[l][NUM/2] <= tree_q[l-1][NUM-1];
                for (int i = (NUM + 1) / 2; i < NUM; i++) tree_q[l][i] <= '0;
            end
        end
    end

    logic signed [A-1:0] acc_q, acc_d, sum_ext, bias_ext;
    logic [CW-1:0]       ch_q, ch_d;
    logic                fire_q, fire_d, last_w;

    assign sum_ext  = {{(A-S){tree_q[T][0][S-1]}}, tree_q[T][0]};
    assign bias_ext = {{(A-DATA){bias_i[DATA-1]}}, bias_i};
    assign last_w   = (ch_q == CW'(CH - 1));

    always_comb begin
        acc_d  = acc_q;
        ch_d   = ch_q;
        fire_d = 1'b0;
        if (clear_i) begin
            acc_d = '0;
            ch_d  = '0;
        end else if (v_q[T]) begin
            acc_d  = (ch_q == '0) ? (sum_ext + bias_ext) : (acc_q + sum_ext);
            ch_d   = last_w ? '0 : ch_q + CW'(1);
            fire_d = last_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            ch_q   <= '0;
            fire_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ch_q   <= ch_d;
            fire_q <= fire_d;
        end
    end

    logic signed [R-1:0]   rnd_w, shr_w;
    logic signed [OUT-1:0] sat_w;
    logic [OUT-1:0]        out_data_q, out_data_d;
    logic                  out_valid_q;

    assign rnd_w = {acc_q[A-1], acc_q} + RND;
    assign shr_w = rnd_w >>> SHIFT;

    always_comb begin
        sat_w = shr_w[OUT-1:0];
        if (RELU != 0 && shr_w[R-1]) begin
            sat_w = '0;
        end else if (shr_w > MAXV) begin
            sat_w = {1'b0, {(OUT-1){1'b1}}};
        end else if (shr_w < MINV) begin
            sat_w = {1'b1, {(OUT-1){1'b0}}};
        end
    end

    assign out_data_d = fire_q ? sat_w : out_data_q;

    // The output register ignores clear so a result already committed still emerges.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= fire_q;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign ch_idx_o    = ch_q;

endmodule
